// File: rtl/core_clk_pkg.sv
// Shared mode encoding and default sizing for the core clock controller.
package core_clk_pkg;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_STEP = 2'b01,
    MODE_RUN  = 2'b10,
    MODE_FAST = 2'b11
  } mode_e;

  localparam int POR_W_DEF      = 25;
  localparam int DEB_CYCLES_DEF = 500000;
  localparam int RST_HOLD_DEF   = 16;
  localparam int DIV_W_DEF      = 8;

endpackage

// File: rtl/core_clk_ctrl_if.sv
// Control/status bundle between the board-level key/mode inputs and the CPU clock-enable logic.
interface core_clk_ctrl_if #(
  parameter int DIV_W = core_clk_pkg::DIV_W_DEF
);
  import core_clk_pkg::*;

  logic             key_rst_n;
  logic             key_step_n;
  mode_e            mode;
  logic [DIV_W-1:0] div;
  logic             rst_req;
  logic             core_rst;
  logic             core_clk_en;
  logic             por_done;
  logic [31:0]      cycle_count;

  modport master (
    output key_rst_n, key_step_n, mode, div, rst_req,
    input  core_rst, core_clk_en, por_done, cycle_count
  );

  modport slave (
    input  key_rst_n, key_step_n, mode, div, rst_req,
    output core_rst, core_clk_en, por_done, cycle_count
  );

endinterface

// File: rtl/core_clk_ctrl_key_debounce.sv
// Two-flop synchroniser plus debouncer for one raw active-low push button.
module key_debounce
  import core_clk_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk50,
  input  logic rst,
  input  logic key_n,
  output logic pressed
);

  localparam int CNT_W = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] stable_cnt;
  logic             differs;

  assign differs = (~sync_p1) ^ pressed;

  always_ff @(posedge clk50) begin
    if (rst) begin
      sync_p0    <= 1'b1;
      sync_p1    <= 1'b1;
      stable_cnt <= '0;
      pressed    <= 1'b0;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
      // Any cycle that agrees with the accepted state restarts the stability window.
      if (!differs) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_W'(DEB_CYCLES - 1)) begin
        stable_cnt <= '0;
        pressed    <= ~pressed;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_clk_ctrl.sv
// CPU clock/reset controller: power-on hold, debounced keys, reset stretching
// and the HALT/STEP/RUN/FAST advance-strobe generator with a strobe counter.
module core_clk_ctrl
  import core_clk_pkg::*;
#(
  parameter int POR_W      = POR_W_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int RST_HOLD   = RST_HOLD_DEF,
  parameter int DIV_W      = DIV_W_DEF
) (
  input logic            clk50,
  input logic            rst,
  core_clk_ctrl_if.slave bus
);

  localparam int HOLD_W = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);

  logic [POR_W:0]    por_cnt;
  logic              por_sat;
  logic              rst_key_pressed;
  logic              step_pressed;
  logic              step_prev;
  logic              step_rise;
  logic [HOLD_W-1:0] hold_cnt;
  logic              rst_src;
  logic              core_rst;
  mode_e             mode_q;
  logic              mode_chg;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_cnt;
  logic              div_hit;
  logic              strobe;
  logic [31:0]       cnt_q;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_rst (
    .clk50   (clk50),
    .rst     (rst),
    .key_n   (bus.key_rst_n),
    .pressed (rst_key_pressed)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_step (
    .clk50   (clk50),
    .rst     (rst),
    .key_n   (bus.key_step_n),
    .pressed (step_pressed)
  );

  // The POR counter saturates on its top bit, so that bit alone marks completion.
  assign por_sat   = por_cnt[POR_W];
  assign rst_src   = rst | ~por_sat | rst_key_pressed | bus.rst_req;
  assign core_rst  = rst_src | (hold_cnt != '0);
  assign mode_chg  = (bus.mode != mode_q);
  assign step_rise = step_pressed & ~step_prev;
  assign div_hit   = (div_cnt >= div_q);

  always_comb begin
    strobe = 1'b0;
    if (!core_rst && !mode_chg) begin
      case (bus.mode)
        MODE_STEP: strobe = step_rise;
        MODE_RUN:  strobe = div_hit;
        MODE_FAST: strobe = 1'b1;
        default:   strobe = 1'b0;
      endcase
    end
  end

  // mode_q/div_q simply track their inputs; mode_q makes a mode change visible for one cycle.
  always_ff @(posedge clk50) begin
    mode_q <= bus.mode;
    div_q  <= bus.div;
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      por_cnt   <= '0;
      hold_cnt  <= '0;
      step_prev <= 1'b0;
      div_cnt   <= '0;
      cnt_q     <= '0;
    end else begin
      if (!por_sat) begin
        por_cnt <= por_cnt + 1'b1;
      end
      if (rst_src) begin
        hold_cnt <= HOLD_W'(RST_HOLD);
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      step_prev <= step_pressed;
      if (core_rst || mode_chg || (bus.mode != MODE_RUN) || div_hit) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (core_rst) begin
        cnt_q <= '0;
      end else if (strobe) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign bus.core_rst    = core_rst;
  assign bus.core_clk_en = strobe;
  assign bus.por_done    = por_sat & ~rst;
  assign bus.cycle_count = core_rst ? 32'd0 : cnt_q;

endmodule

// File: doc/core_clk_ctrl.md
CORE_CLK_CTRL -- requirements
Module: core_clk_ctrl

Interface
REQ-001 Parameter POR_W, default 25: power-on hold lasts 2^POR_W clk50 cycles.
REQ-002 Parameter DEB_CYCLES, default 500000: stable-input cycles required to accept a key change (10 ms at 50 MHz).
REQ-003 Parameter RST_HOLD, default 16: core_rst stretch, in cycles, after the last reset source clears.
REQ-004 Parameter DIV_W, default 8: width of the run-mode divider.
REQ-005 clk50  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 key_rst_n  in  1  raw active-low reset button, asynchronous to clk50.
REQ-008 key_step_n  in  1  raw active-low single-step button, asynchronous to clk50.
REQ-009 mode  in  2  00 HALT, 01 STEP, 10 RUN, 11 FAST.
REQ-010 div  in  DIV_W  RUN-mode period minus one.
REQ-011 rst_req  in  1  CPU-issued reset request (level or single-cycle pulse).
REQ-012 core_rst  out  1  synchronous active-high CPU-domain reset.
REQ-013 core_clk_en  out  1  one-cycle CPU advance strobe.
REQ-014 por_done  out  1  power-on sequence complete.
REQ-015 cycle_count  out  32  number of core_clk_en strobes since core_rst last released.

Function
REQ-016 Each raw key SHALL pass through a 2-flop synchroniser followed by a debouncer; the debounced "pressed" output SHALL change only after the synchronised input has differed from it for DEB_CYCLES consecutive cycles.
REQ-017 The POR counter SHALL increment each cycle until it reaches 2^POR_W, then saturate; por_done SHALL be high exactly when the counter is saturated.
REQ-018 Reset sources: !por_done, debounced reset key pressed, rst_req.
REQ-019 core_rst SHALL be high on every cycle where any source is active, and SHALL stay high for exactly RST_HOLD further cycles after the last source drops; a source reasserting during the hold SHALL restart the hold.
REQ-020 core_clk_en SHALL be 0 on every cycle where core_rst is high.
REQ-021 cycle_count SHALL be 0 while core_rst is high; it SHALL increment by 1 on each core_clk_en and wrap from 2^32-1 to 0.
REQ-022 HALT: core_clk_en SHALL stay 0.
REQ-023 STEP: a rising edge of debounced step-pressed SHALL produce exactly one core_clk_en on the next cycle; edges during core_rst, or in any other mode, SHALL be discarded, not queued.
REQ-024 RUN: the divider counter SHALL be held at 0 while core_rst is high; otherwise it SHALL assert core_clk_en and return to 0 when counter >= div, and increment otherwise; period is div+1 cycles; div=0 gives a strobe every cycle.
REQ-025 RUN: the first strobe after core_rst falls SHALL occur on the (div+1)-th cycle with core_rst low.
REQ-026 A lowered div that is already <= the counter SHALL cause a strobe on the next cycle, after which the new period applies.
REQ-027 FAST: core_clk_en SHALL be 1 on every cycle with core_rst low, regardless of div.
REQ-028 Any change of mode SHALL clear the divider counter on that cycle and SHALL produce no strobe on that cycle.

Reset
REQ-029 rst SHALL clear the POR counter and therefore rerun the full power-on sequence.
REQ-030 While rst is high: core_rst=1, core_clk_en=0, por_done=0, cycle_count=0, divider=0, debounced outputs=not pressed, synchroniser flops=1 (released), hold counter=0.

Structure
REQ-031 Package core_clk_pkg SHALL hold the mode enum (MODE_HALT, MODE_STEP, MODE_RUN, MODE_FAST) and the default parameter constants.
REQ-032 Sub-module key_debounce (synchroniser plus debouncer, parameter DEB_CYCLES) SHALL be instantiated once per key.

Verification (POR_W=4, DEB_CYCLES=4, RST_HOLD=3, DIV_W=4)
REQ-033 Pulse rst, mode=FAST -> por_done rises after 16 cycles; core_rst falls 3 cycles later; core_clk_en then stays high every cycle.
REQ-034 RUN, div=3, after release -> strobe every 4th cycle, first on cycle 4; cycle_count=5 after 20 cycles.
REQ-035 STEP: key_step_n low for 2 cycles -> no strobe; low for 10 cycles -> exactly one strobe, cycle_count +1; second press in HALT -> none.
REQ-036 One-cycle rst_req mid-RUN -> core_rst high for 4 cycles; cycle_count=0; no strobes during; RUN restarts with full period.
REQ-037 RUN: div changed 7->2 while counter=5 -> strobe on next cycle, then every 3 cycles.
REQ-038 key_rst_n held low 10 cycles -> core_rst asserts after synchroniser plus debounce delay and releases RST_HOLD cycles after the debounced release.
